// File: rtl/uart_lcd_text_buffer_if.sv
// UART receiver to text buffer handshake: level-valid byte plus one-cycle read pulse.
interface uart_lcd_text_buffer_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_read_en;

  modport master (output rx_data, output rx_valid, input rx_read_en);
  modport slave  (input rx_data, input rx_valid, output rx_read_en);
endinterface

// File: rtl/uart_lcd_text_buffer.sv
// 2x16 LCD character frame fed from the UART: printable ASCII plus CR, LF, BS, FF.
// state   | meaning
// S_IDLE  | waiting for rx_valid, latch byte into cmd
// S_EXEC  | acknowledge byte, execute cmd
// S_CLEAR | blank one cell per cycle after FF
// S_DRAIN | wait for rx_valid to drop before accepting again
module uart_lcd_text_buffer #(
  parameter int          ROWS  = 2,
  parameter int          COLS  = 16,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_lcd_text_buffer_if.slave  rx,
  input  logic [4:0]             rd_addr,
  output logic [7:0]             rd_char,
  output logic                   dirty,
  input  logic                   dirty_clr,
  output logic                   cursor_row,
  output logic [3:0]             cursor_col,
  output logic [1:0]             debug_state
);

  localparam int         CELLS    = ROWS * COLS;
  localparam logic [4:0] LAST_IDX = 5'(CELLS - 1);
  localparam logic [3:0] LAST_COL = 4'(COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_CLEAR = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] cmd;
  logic [4:0] clr_idx;
  logic       read_en_q;
  logic [7:0] frame [CELLS];

  assign rx.rx_read_en = read_en_q;
  assign debug_state   = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      read_en_q  <= 1'b0;
      dirty      <= 1'b0;
      cursor_row <= 1'b0;
      cursor_col <= 4'd0;
      cmd        <= 8'h00;
      clr_idx    <= 5'd0;
      rd_char    <= BLANK;
      for (int i = 0; i < CELLS; i++) frame[i] <= BLANK;
    end else begin
      // Non-blocking read gives read-before-write on a same-cell collision.
      rd_char <= frame[rd_addr];
      if (dirty_clr) dirty <= 1'b0;

      case (state)
        S_IDLE: begin
          read_en_q <= 1'b0;
          if (rx.rx_valid) begin
            cmd       <= rx.rx_data;
            read_en_q <= 1'b1;
            state     <= S_EXEC;
          end
        end

        S_EXEC: begin
          read_en_q <= 1'b0;
          state     <= S_DRAIN;
          if (cmd >= 8'h20 && cmd <= 8'h7E) begin
            frame[{cursor_row, cursor_col}] <= cmd;
            dirty <= 1'b1;
            if (cursor_col == LAST_COL) begin
              cursor_col <= 4'd0;
              cursor_row <= ~cursor_row;
            end else begin
              cursor_col <= cursor_col + 4'd1;
            end
          end else if (cmd == 8'h0D) begin
            cursor_col <= 4'd0;
          end else if (cmd == 8'h0A) begin
            cursor_col <= 4'd0;
            cursor_row <= ~cursor_row;
          end else if (cmd == 8'h08) begin
            if (cursor_col != 4'd0) begin
              cursor_col <= cursor_col - 4'd1;
              frame[{cursor_row, cursor_col - 4'd1}] <= BLANK;
              dirty <= 1'b1;
            end
          end else if (cmd == 8'h0C) begin
            cursor_row <= 1'b0;
            cursor_col <= 4'd0;
            clr_idx    <= 5'd0;
            dirty      <= 1'b1;
            state      <= S_CLEAR;
          end
        end

        S_CLEAR: begin
          read_en_q      <= 1'b0;
          frame[clr_idx] <= BLANK;
          clr_idx        <= clr_idx + 5'd1;
          if (clr_idx == LAST_IDX) state <= S_DRAIN;
        end

        S_DRAIN: begin
          read_en_q <= 1'b0;
          if (!rx.rx_valid) state <= S_IDLE;
        end

        default: begin
          read_en_q <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
